// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW countdown stall, branch/jump flushes, memory freeze, halt.
// Optional PIPE_CTRL_FWD_EN build: forwarding present, only load-use hazards stall for one cycle.
module pipe_ctrl #(
  parameter int AW       = 3,
  parameter int ST_IDEX  = 3,
  parameter int ST_EXMEM = 2,
  parameter int ST_MEMWB = 1,
  parameter int PCW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd1_addr_ifid,
  input  logic [AW-1:0] rd2_addr_ifid,
  input  logic          rd1_used_ifid,
  input  logic          rd2_used_ifid,
  input  logic [AW-1:0] wrr_idex,
  input  logic [AW-1:0] wrr_exmem,
  input  logic [AW-1:0] wrr_memwb,
  input  logic          regwrite_idex,
  input  logic          regwrite_exmem,
  input  logic          regwrite_memwb,
  input  logic          memread_idex,
  input  logic          take_branch_exmem,
  input  logic          jump_idex,
  input  logic          mem_busy,
  input  logic          halt_memwb,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          exmem_en,
  output logic          memwb_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          halted,
  output logic [1:0]    stall_cnt,
  output logic [PCW-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, RAW, HALT} state_t;

  state_t     state;
  logic       jump_pend;
  logic       m_idex, m_exmem, m_memwb;
  logic [1:0] need;

  function automatic logic src_match(input logic [AW-1:0] wrr, input logic rw);
    return rw & ((rd1_used_ifid & (wrr == rd1_addr_ifid)) |
                 (rd2_used_ifid & (wrr == rd2_addr_ifid)));
  endfunction

  assign m_idex  = src_match(wrr_idex,  regwrite_idex);
  assign m_exmem = src_match(wrr_exmem, regwrite_exmem);
  assign m_memwb = src_match(wrr_memwb, regwrite_memwb);

`ifdef PIPE_CTRL_FWD_EN
  // Older producers are covered by the bypass network; only a load cannot forward in time.
  logic unused_older;
  assign unused_older = m_exmem | m_memwb;
  assign need = (m_idex & memread_idex) ? 2'd1 : 2'd0;
`else
  logic unused_memread;
  assign unused_memread = memread_idex;
  always_comb begin
    need = 2'd0;
    if (m_idex)       need = 2'(ST_IDEX);
    else if (m_exmem) need = 2'(ST_EXMEM);
    else if (m_memwb) need = 2'(ST_MEMWB);
  end
`endif

  assign halted = (state == HALT);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (state == HALT || mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (halt_memwb) begin
      // HALT retires normally this cycle; the freeze starts next cycle.
    end else if (take_branch_exmem) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == RAW || need != 2'd0) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      ifid_flush = jump_idex | jump_pend;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      stall_cnt    <= 2'd0;
      jump_pend    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en && state != HALT && !(&stall_cycles))
        stall_cycles <= stall_cycles + 1'b1;
      if (state == HALT || mem_busy) begin
        // frozen: state, countdown and pending jump flush all hold
      end else if (halt_memwb) begin
        state <= HALT;
      end else if (take_branch_exmem) begin
        state     <= RUN;
        stall_cnt <= 2'd0;
        jump_pend <= 1'b0;
      end else if (state == RAW) begin
        stall_cnt <= stall_cnt - 2'd1;
        if (stall_cnt <= 2'd1) state <= RUN;
        jump_pend <= jump_idex;
      end else if (need != 2'd0) begin
        stall_cnt <= need - 2'd1;
        state     <= (need > 2'd1) ? RAW : RUN;
        jump_pend <= jump_idex;
      end else begin
        jump_pend <= jump_idex;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle vector table from reset plus multi-cycle corner sequences.
module tb_pipe_ctrl;

  logic       clk, rst;
  logic [2:0] rd1_addr_ifid, rd2_addr_ifid, wrr_idex, wrr_exmem, wrr_memwb;
  logic       rd1_used_ifid, rd2_used_ifid;
  logic       regwrite_idex, regwrite_exmem, regwrite_memwb, memread_idex;
  logic       take_branch_exmem, jump_idex, mem_busy, halt_memwb;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
  logic [1:0] stall_cnt;
  logic [15:0] stall_cycles;

  int total = 0;
  int passed = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .rd1_addr_ifid(rd1_addr_ifid), .rd2_addr_ifid(rd2_addr_ifid),
    .rd1_used_ifid(rd1_used_ifid), .rd2_used_ifid(rd2_used_ifid),
    .wrr_idex(wrr_idex), .wrr_exmem(wrr_exmem), .wrr_memwb(wrr_memwb),
    .regwrite_idex(regwrite_idex), .regwrite_exmem(regwrite_exmem), .regwrite_memwb(regwrite_memwb),
    .memread_idex(memread_idex), .take_branch_exmem(take_branch_exmem), .jump_idex(jump_idex),
    .mem_busy(mem_busy), .halt_memwb(halt_memwb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .stall_cnt(stall_cnt), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rd1, rd2;
    logic       u1, u2;
    logic [2:0] wi, we, wm;
    logic       rwi, rwe, rwm, mr, br, jmp, busy;
    logic [6:0] eo;   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    logic [1:0] cnt;  // stall_cnt after the edge
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd1_addr_ifid = 3'd1; rd2_addr_ifid = 3'd2; rd1_used_ifid = 1'b1; rd2_used_ifid = 1'b1;
    wrr_idex = 3'd4; wrr_exmem = 3'd5; wrr_memwb = 3'd6;
    regwrite_idex = 1'b0; regwrite_exmem = 1'b0; regwrite_memwb = 1'b0; memread_idex = 1'b0;
    take_branch_exmem = 1'b0; jump_idex = 1'b0; mem_busy = 1'b0; halt_memwb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    rd1_addr_ifid = v.rd1; rd2_addr_ifid = v.rd2; rd1_used_ifid = v.u1; rd2_used_ifid = v.u2;
    wrr_idex = v.wi; wrr_exmem = v.we; wrr_memwb = v.wm;
    regwrite_idex = v.rwi; regwrite_exmem = v.rwe; regwrite_memwb = v.rwm; memread_idex = v.mr;
    take_branch_exmem = v.br; jump_idex = v.jmp; mem_busy = v.busy; halt_memwb = 1'b0;
  endtask

  task automatic hazard_idex(input logic load);
    idle();
    rd1_addr_ifid = 3'd3; wrr_idex = 3'd3; regwrite_idex = 1'b1; memread_idex = load;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef PIPE_CTRL_FWD_EN
    tbl.push_back('{3'd1,3'd2,1'b1,1'b1,3'd4,3'd5,3'd6,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,7'b0011101,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd1,3'd4,1'b1,1'b1,3'd6,3'd4,3'd7,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd1,3'd5,1'b1,1'b1,3'd6,3'd7,3'd5,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,7'b1111111,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,7'b0000000,2'd0});
`else
    tbl.push_back('{3'd1,3'd2,1'b1,1'b1,3'd4,3'd5,3'd6,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,7'b0011101,2'd2});
    tbl.push_back('{3'd1,3'd4,1'b1,1'b1,3'd6,3'd4,3'd7,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b0011101,2'd1});
    tbl.push_back('{3'd1,3'd5,1'b1,1'b1,3'd6,3'd7,3'd5,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b0011101,2'd0});
    tbl.push_back('{3'd1,3'd5,1'b1,1'b0,3'd6,3'd7,3'd5,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd2,3'd1,1'b1,1'b1,3'd2,3'd2,3'd2,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b0011101,2'd2});
    tbl.push_back('{3'd2,3'd1,1'b1,1'b1,3'd2,3'd2,3'd6,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,7'b0011101,2'd1});
    tbl.push_back('{3'd3,3'd2,1'b0,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,7'b1111100,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,7'b0011101,2'd2});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,7'b1111111,2'd0});
    tbl.push_back('{3'd1,3'd2,1'b1,1'b1,3'd4,3'd5,3'd6,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,7'b1111110,2'd0});
    tbl.push_back('{3'd3,3'd2,1'b1,1'b1,3'd3,3'd5,3'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,7'b0000000,2'd0});
`endif

    idle();
    rst = 1'b0;
    #12;
    chk("rst_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    chk("rst_flushes", {ifid_flush, idex_flush}, 2'b00);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      do_reset();
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_pc_en", i),      pc_en,      tbl[i].eo[6]);
      chk($sformatf("v%0d_ifid_en", i),    ifid_en,    tbl[i].eo[5]);
      chk($sformatf("v%0d_idex_en", i),    idex_en,    tbl[i].eo[4]);
      chk($sformatf("v%0d_exmem_en", i),   exmem_en,   tbl[i].eo[3]);
      chk($sformatf("v%0d_memwb_en", i),   memwb_en,   tbl[i].eo[2]);
      chk($sformatf("v%0d_ifid_flush", i), ifid_flush, tbl[i].eo[1]);
      chk($sformatf("v%0d_idex_flush", i), idex_flush, tbl[i].eo[0]);
      tick();
      chk($sformatf("v%0d_stall_cnt", i),  stall_cnt,  tbl[i].cnt);
    end

`ifdef PIPE_CTRL_FWD_EN
    // load-use: exactly one stall cycle, then free-running
    do_reset();
    hazard_idex(1'b1);
    #1;
    chk("lu_pc_en0", pc_en, 0);
    tick();
    idle();
    #1;
    chk("lu_pc_en1", pc_en, 1);
    chk("lu_stall_cycles", stall_cycles, 1);
`else
    // full three-cycle RAW stall from an ID/EX producer
    do_reset();
    hazard_idex(1'b0);
    #1;
    chk("raw_c0_pc_en", pc_en, 0);
    tick();
    chk("raw_c0_cnt", stall_cnt, 2);
    idle();
    #1;
    chk("raw_c1_pc_en", pc_en, 0);
    chk("raw_c1_bubble", idex_flush, 1);
    tick();
    chk("raw_c1_cnt", stall_cnt, 1);
    chk("raw_c2_pc_en", pc_en, 0);
    chk("raw_c2_bubble", idex_flush, 1);
    tick();
    chk("raw_c2_cnt", stall_cnt, 0);
    chk("raw_c3_pc_en", pc_en, 1);
    chk("raw_stall_cycles", stall_cycles, 3);

    // taken branch aborts a RAW stall at its last count
    do_reset();
    hazard_idex(1'b0);
    tick();
    idle();
    tick();
    chk("brk_cnt_pre", stall_cnt, 1);
    take_branch_exmem = 1'b1;
    #1;
    chk("brk_pc_en", pc_en, 1);
    chk("brk_flushes", {ifid_flush, idex_flush}, 2'b11);
    tick();
    take_branch_exmem = 1'b0;
    chk("brk_cnt", stall_cnt, 0);
    #1;
    chk("brk_run_pc_en", pc_en, 1);

    // mem_busy freezes the countdown; async reset mid-stall clears it
    do_reset();
    hazard_idex(1'b0);
    tick();
    idle();
    mem_busy = 1'b1;
    #1;
    chk("busy_enables", {pc_en, idex_en, memwb_en}, 3'b000);
    chk("busy_flushes", {ifid_flush, idex_flush}, 2'b00);
    tick();
    chk("busy_cnt_hold", stall_cnt, 2);
    mem_busy = 1'b0;
    tick();
    chk("busy_cnt_resume", stall_cnt, 1);
    rst = 1'b0;
    #1;
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_pc_en", pc_en, 1);
    chk("arst_stall_cycles", stall_cycles, 0);
    rst = 1'b1;
`endif

    // jump flush survives an intervening memory freeze
    tick();
    do_reset();
    idle();
    jump_idex = 1'b1;
    #1;
    chk("jmp_c0_flush", ifid_flush, 1);
    tick();
    jump_idex = 1'b0;
    mem_busy = 1'b1;
    #1;
    chk("jmp_c1_flush", ifid_flush, 0);
    chk("jmp_c1_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
    tick();
    mem_busy = 1'b0;
    #1;
    chk("jmp_c2_flush", ifid_flush, 1);
    chk("jmp_c2_pc_en", pc_en, 1);
    tick();
    chk("jmp_c3_flush", ifid_flush, 0);

    // halt: frozen until reset, stall counter untouched
    halt_memwb = 1'b1;
    tick();
    halt_memwb = 1'b0;
    chk("halt_halted", halted, 1);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("halt_en_%0d", k), {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      tick();
    end
    chk("halt_flushes", {ifid_flush, idex_flush}, 2'b00);
    chk("halt_stall_cycles", stall_cycles, 1);
    rst = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc_en", pc_en, 1);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB) of the 8-register core. It turns the raw producer/consumer register matches, branch, jump, memory-busy and halt indications into per-stage enables and flushes. RAW stalls are tracked with a countdown counter instead of chained flops, and a redirect aborts any pending stall. Sits beside the pipeline registers and drives their en/flush pins directly.

Parameters:
AW, 3, register address width
ST_IDEX, 3, RAW stall depth when the nearest producer is in ID/EX
ST_EXMEM, 2, RAW stall depth when the nearest producer is in EX/MEM
ST_MEMWB, 1, RAW stall depth when the nearest producer is in MEM/WB
PCW, 16, width of the stall performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset; 0 clears all state immediately
rd1_addr_ifid  in  AW  source 1 of instruction in IF/ID
rd2_addr_ifid  in  AW  source 2 of instruction in IF/ID
rd1_used_ifid, rd2_used_ifid  in  1 each  source actually read
wrr_idex, wrr_exmem, wrr_memwb  in  AW each  destination per stage
regwrite_idex, regwrite_exmem, regwrite_memwb  in  1 each  stage writes a register
memread_idex  in  1  ID/EX instruction is a load
take_branch_exmem  in  1  taken branch resolved in EX/MEM
jump_idex  in  1  jump in ID/EX
mem_busy  in  1  data memory not ready; freeze pipeline
halt_memwb  in  1  HALT reached MEM/WB
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
ifid_flush, idex_flush  out  1 each  load a NOP into the register
halted  out  1  core stopped
stall_cnt  out  2  remaining RAW stall cycles
stall_cycles  out  PCW  saturating count of cycles with pc_en=0 while not halted

Behaviour:
- Reset (rst=0, async): state RUN, stall_cnt=0, jump flush counter=0, stall_cycles=0, halted=0; all enables 1, flushes 0.
- States: RUN, RAW, HALT.
- Match m_X = regwrite_X & ((rd1_used & wrr_X==rd1_addr) | (rd2_used & wrr_X==rd2_addr)). need = ST_IDEX if m_idex, else ST_EXMEM if m_exmem, else ST_MEMWB if m_memwb, else 0. Nearest producer wins.
- RUN with need>0 (and no higher-priority event): pc_en=ifid_en=0 and idex_flush=1 combinationally in the same cycle. stall_cnt<=need-1. Go to RAW if need>1.
- RAW: hold PC and IF/ID, bubble into ID/EX, stall_cnt decrements. Leave RAW when stall_cnt reaches 1 and that cycle ends. need is not re-evaluated in RAW.
- Branch (take_branch_exmem=1): ifid_flush=idex_flush=1, stall_cnt<=0, state RUN, jump flush counter cleared, pc_en=1. Highest priority after mem_busy/HALT.
- Jump (jump_idex=1): ifid_flush=1 this cycle and the next. A 1-bit counter covers the second cycle. No effect on the RAW counter.
- mem_busy=1: every enable 0, no flushes. stall_cnt, state and the jump counter hold; pending events resume afterwards. A branch that arrives during mem_busy acts on the first non-busy cycle (its input holds because EX/MEM is frozen).
- halt_memwb=1 (not busy): next state HALT. In HALT all enables are 0, halted=1, flushes are 0, and only reset leaves HALT.
- Priority: reset > HALT > mem_busy > branch > RAW/stall > jump flush.
- stall_cycles increments when pc_en=0 and state≠HALT, and saturates at all-ones.
- Reset asserted mid-stall: immediate return to the reset values.

Optional Feature:
PIPE_CTRL_FWD_EN:
- Defined: a forwarding network exists. need=1 only when m_idex & memread_idex (load-use), otherwise 0. EX/MEM and MEM/WB matches never stall, and the RAW state is unreachable.
- Undefined: the full depth table above applies, and memread_idex is ignored.

Test Plan:
- Reset held low, then released -> all enables 1, flushes 0, stall_cnt 0, stall_cycles 0.
- ADD r3 in ID/EX, consumer reads r3 in IF/ID -> pc_en=0 for exactly 3 cycles, stall_cnt 2,1,0, three bubbles, stall_cycles=3.
- Producer r5 only in MEM/WB, consumer rd2=r5 with rd2_used=1 -> 1-cycle stall. Same case with rd2_used=0 -> no stall.
- RAW stall at stall_cnt=1 plus take_branch_exmem=1 -> same cycle ifid_flush=idex_flush=1, pc_en=1, stall_cnt=0, RUN.
- jump_idex pulse for 1 cycle with mem_busy=1 on the following cycle -> ifid_flush in cycle 0; enables 0 in cycle 1; second flush in cycle 2.
- halt_memwb=1 -> halted=1 from the next cycle, all enables 0 for 10 cycles; stall_cycles unchanged; rst low clears it.
- With PIPE_CTRL_FWD_EN, load r2 in ID/EX plus consumer r2 -> 1-cycle stall. Non-load producer -> 0 stalls.
